regfile_clear: RTL and testbench
================================

Name: regfile_clear

Overview:
- 32 x 32-bit integer register file for the single-cycle RV32I core; sits directly upstream of the ALU.
- Two combinational read ports drive the ALU operand inputs (rs1 drives operand A; rs2 drives operand B, or the immediate mux feeding B).
- One synchronous write port takes the writeback result (ALU result / load data).
- After reset, a sequential clear engine zeroes x1..x31 one register per cycle; the core is held off with o_ready until clearing finishes.

Parameters:
- XLEN, 32, register data width in bits.
- CLEAR_ON_RESET, 1, 1 = run the post-reset clear sequence; 0 = skip it (contents undefined after reset).

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_rs1Addr  input  5  read port 1 address.
- i_rs2Addr  input  5  read port 2 address.
- o_rs1Data  output  XLEN  read port 1 data (to ALU operand A).
- o_rs2Data  output  XLEN  read port 2 data (to ALU operand B mux).
- i_rdAddr  input  5  write address.
- i_rdData  input  XLEN  write data (writeback value).
- i_rdWriteEnable  input  1  write strobe.
- o_ready  output  1  1 = clear complete, register file usable.

Behaviour:
- State machine, 2 states: CLEAR, READY. Clear index idx is a 5-bit counter.
- Reset: on an edge with i_rst=1, state<=CLEAR and idx<=1 (CLEAR_ON_RESET=1), or state<=READY (CLEAR_ON_RESET=0). i_rst has priority over all other activity.
- o_ready reset value is 0; o_ready = (state==READY), registered.
- CLEAR state:
  - Each edge with i_rst=0: regs[idx]<=0, idx<=idx+1.
  - On the edge clearing idx==31: state<=READY.
  - Sequence: exactly 31 edges after the first edge with i_rst deasserted, then o_ready=1.
- CLEAR_ON_RESET=0: o_ready=1 from the first edge after i_rst deasserts.
- During CLEAR:
  - i_rdWriteEnable is ignored; no user write occurs.
  - o_rs1Data and o_rs2Data are forced to 0.
- Reset mid-clear: restarts at idx=1, o_ready stays 0. Reset while READY also returns to CLEAR.
- Reads in READY:
  - Combinational (asynchronous), zero-cycle latency: o_rsNData = regs[i_rsNAddr].
  - Address 0 always reads 0.
- Writes in READY:
  - On an edge with i_rdWriteEnable=1 and i_rdAddr!=0: regs[i_rdAddr]<=i_rdData.
  - Writes to x0 are discarded; x0 has no storage.
- Same-cycle read/write of the same non-zero register: the returned value depends on the optional feature below.
- Both read ports may address the same register, including x0, in the same cycle; both return the same value.
- No X propagation on outputs: all read data is a defined 0 during CLEAR and reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If state==READY, i_rdWriteEnable=1, i_rdAddr!=0 and i_rdAddr==i_rsNAddr, then o_rsNData=i_rdData (write-through, combinational).
  - Applies independently to each read port.
  - x0 is never bypassed.
- Not defined: the read returns the pre-write (old) register contents; the new value is visible from the cycle after the write edge.

Test Plan:
- Reset/clear timing: hold i_rst=1 for 3 cycles, release. o_ready=0 for 31 edges, 1 after the 31st. Then read x1..x31 on both ports: all 0x00000000.
- Basic write/read: write x5=0xDEADBEEF, next cycle rs1=5, rs2=5. Both ports read 0xDEADBEEF. Write x31=0x12345678, read rs2=31: 0x12345678.
- x0 hardwiring: write x0=0xFFFFFFFF. Read rs1=0: 0x00000000. Register x1 is unaffected.
- Writes blocked during CLEAR: after reset, assert write x7=0xAAAA5555 at clear cycle 3. After o_ready=1, x7 reads 0. During CLEAR, any rs address reads 0.
- Reset mid-clear: assert i_rst at clear cycle 20, release. o_ready rises exactly 31 edges after release, not earlier.
- Bypass: x9 holds 0x11111111; in the same cycle write x9=0x22222222 and read rs1=9. With REGFILE_BYPASS_EN, o_rs1Data=0x22222222. Without it, 0x11111111, then 0x22222222 the next cycle.

Source files
------------

// File: rtl/regfile_clear_if.sv
// regfile_clear_if: read/write bus between the RV32I core and its register file.
// The core (master) drives the addresses and writeback data. The register file
// (slave) returns both operands and the ready flag.
interface regfile_clear_if #(
  parameter int XLEN = 32
);
  logic [4:0]      i_rs1Addr;
  logic [4:0]      i_rs2Addr;
  logic [XLEN-1:0] o_rs1Data;
  logic [XLEN-1:0] o_rs2Data;
  logic [4:0]      i_rdAddr;
  logic [XLEN-1:0] i_rdData;
  logic            i_rdWriteEnable;
  logic            o_ready;

  modport master (
    output i_rs1Addr, i_rs2Addr, i_rdAddr, i_rdData, i_rdWriteEnable,
    input  o_rs1Data, o_rs2Data, o_ready
  );

  modport slave (
    input  i_rs1Addr, i_rs2Addr, i_rdAddr, i_rdData, i_rdWriteEnable,
    output o_rs1Data, o_rs2Data, o_ready
  );
endinterface

// File: rtl/regfile_clear.sv
// regfile_clear: 32 x XLEN integer register file with a post-reset clear engine.
// After reset, x1..x31 are zeroed one per cycle. o_ready stays low until that finishes.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write is forwarded to a matching
// read port. Without it, a read returns the pre-write contents.
module regfile_clear #(
  parameter int XLEN           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  regfile_clear_if.slave rf
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic            ready_q, ready_d;

  // x0 has no storage; it is synthesised as a constant zero on the read side.
  logic [XLEN-1:0] regs_q [31:1];
  logic [XLEN-1:0] regs_d [31:1];

  logic            wr_en;
  logic            rd_ok;

  // User writes are accepted only once the file is declared usable. Reset on the
  // same edge always wins.
  assign wr_en = ready_q && !i_rst && rf.i_rdWriteEnable && (rf.i_rdAddr != 5'd0);

  // Reads return a defined zero while clearing or under reset, so no X reaches the ALU.
  assign rd_ok = ready_q && !i_rst;

  // Next-state logic for the clear engine and the ready flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_CLEAR: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) state_d = S_READY;
      end
      S_READY: ;
      default: state_d = S_CLEAR;
    endcase
    // ready follows the state the FSM is about to enter. With the clear engine
    // disabled, it therefore rises on the first edge after reset deasserts.
    ready_d = (state_d == S_READY);
  end

  // Control registers, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      idx_q   <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Next contents of the array: a clear write while clearing, otherwise the user write.
  always_comb begin
    regs_d = regs_q;
    if (state_q == S_CLEAR) begin
      if (idx_q != 5'd0) regs_d[idx_q] = '0;
    end else if (wr_en) begin
      regs_d[rf.i_rdAddr] = rf.i_rdData;
    end
  end

  // Storage array. It has no reset; the clear engine defines the contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst) regs_q <= regs_d;
  end

  // Read port 1, to ALU operand A.
  always_comb begin
    rf.o_rs1Data = '0;
    if (rd_ok && rf.i_rs1Addr != 5'd0) begin
      rf.o_rs1Data = regs_q[rf.i_rs1Addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && rf.i_rdAddr == rf.i_rs1Addr) rf.o_rs1Data = rf.i_rdData;
`endif
    end
  end

  // Read port 2, to the ALU operand B mux.
  always_comb begin
    rf.o_rs2Data = '0;
    if (rd_ok && rf.i_rs2Addr != 5'd0) begin
      rf.o_rs2Data = regs_q[rf.i_rs2Addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && rf.i_rdAddr == rf.i_rs2Addr) rf.o_rs2Data = rf.i_rdData;
`endif
    end
  end

  assign rf.o_ready = ready_q;

endmodule

// File: tb/tb_regfile_clear.sv
// tb_regfile_clear: random and directed stimulus for regfile_clear. A behavioural
// model (edge counter plus a plain array) is checked against the DUT every cycle.
`timescale 1ns/1ps
module tb_regfile_clear;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_clear_if #(.XLEN(32)) bus ();

  regfile_clear #(.XLEN(32), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rf    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [31:0] m_regs [32];
  int          m_edges = 0;
  logic        m_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || !m_ready || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.i_rdWriteEnable && bus.i_rdAddr != 5'd0 && bus.i_rdAddr == a) return bus.i_rdData;
`endif
    return m_regs[a];
  endfunction

  // Model update. Ready comes after 31 consecutive non-reset edges, and by then
  // every register is zero. After that, writes to non-zero addresses land.
  always @(posedge clk) begin
    if (rst) begin
      m_edges <= 0;
      m_ready <= 1'b0;
    end else if (!m_ready) begin
      if (m_edges == 30) begin
        m_ready <= 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      end
      m_edges <= m_edges + 1;
    end else if (bus.i_rdWriteEnable && bus.i_rdAddr != 5'd0) begin
      m_regs[bus.i_rdAddr] <= bus.i_rdData;
    end
  end

  // Compare process, run on every cycle away from the active edge.
  always @(negedge clk) begin
    chk("ready", {31'h0, bus.o_ready}, {31'h0, m_ready});
    chk("rs1", bus.o_rs1Data, exp_rd(bus.i_rs1Addr));
    chk("rs2", bus.o_rs2Data, exp_rd(bus.i_rs2Addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] a1, input logic [4:0] a2, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    bus.i_rs1Addr       = a1;
    bus.i_rs2Addr       = a2;
    bus.i_rdWriteEnable = we;
    bus.i_rdAddr        = wa;
    bus.i_rdData        = wd;
  endtask

  initial begin
    drv(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_ready", {31'h0, bus.o_ready}, 32'h0);
    chk("reset_rs1", bus.o_rs1Data, 32'h0);

    // Release reset and count edges through the clear. A write at clear cycle 3 must be dropped.
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 3) drv(5'd7, 5'd7, 1'b1, 5'd7, 32'hAAAA5555);
      else        drv(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 5'd0, 32'h0);
      tick();
      chk("clear_ready", {31'h0, bus.o_ready}, (i == 31) ? 32'h1 : 32'h0);
    end

    // All registers read zero on both ports.
    for (int i = 1; i < 32; i++) begin
      drv(5'(i), 5'(i), 1'b0, 5'd0, 32'h0);
      #1;
      if (i == 7) chk("x7_blocked", bus.o_rs1Data, 32'h0);
      tick();
    end
    chk("x31_cleared", bus.o_rs2Data, 32'h0);

    // Basic write/read.
    drv(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF); tick();
    drv(5'd5, 5'd5, 1'b0, 5'd0, 32'h0); #1;
    chk("x5_rs1", bus.o_rs1Data, 32'hDEADBEEF);
    chk("x5_rs2", bus.o_rs2Data, 32'hDEADBEEF);
    tick();
    drv(5'd0, 5'd0, 1'b1, 5'd31, 32'h12345678); tick();
    drv(5'd0, 5'd31, 1'b0, 5'd0, 32'h0); #1;
    chk("x31_rs2", bus.o_rs2Data, 32'h12345678);
    tick();

    // x0 is hardwired to zero.
    drv(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF); tick();
    drv(5'd0, 5'd1, 1'b0, 5'd0, 32'h0); #1;
    chk("x0_rs1", bus.o_rs1Data, 32'h0);
    chk("x1_untouched", bus.o_rs2Data, 32'h0);
    tick();

    // Same-cycle write and read of x9.
    drv(5'd0, 5'd0, 1'b1, 5'd9, 32'h11111111); tick();
    drv(5'd9, 5'd0, 1'b1, 5'd9, 32'h22222222); #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same", bus.o_rs1Data, 32'h22222222);
`else
    chk("bypass_same", bus.o_rs1Data, 32'h11111111);
`endif
    tick();
    drv(5'd9, 5'd0, 1'b0, 5'd0, 32'h0); #1;
    chk("bypass_next", bus.o_rs1Data, 32'h22222222);
    tick();

    // Random traffic with an occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      drv(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), $urandom);
      tick();
    end
    rst = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    repeat (35) tick();

    // Reset mid-clear restarts the full 31-edge sequence.
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (20) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("midclear_ready", {31'h0, bus.o_ready}, (i == 31) ? 32'h1 : 32'h0);
    end
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
